dram_controller: RTL and testbench



---
 rtl/dram_controller_pkg.sv | 48 ++++
 rtl/dram_controller_if.sv | 37 +++
 rtl/dram_controller_wait_cnt.sv | 24 ++
 rtl/dram_controller.sv | 160 ++++++++++++++++
 tb/tb_dram_controller.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_controller_pkg.sv
// Shared types, timing constants and pin encodings for the SDRAM-style DRAM controller.
package dram_ctrl_pkg;

  localparam int unsigned ROW_W_DEF  = 11;
  localparam int unsigned COL_W_DEF  = 10;
  localparam int unsigned A_W_DEF    = 11;
  localparam int unsigned DATA_W_DEF = 32;

  localparam int unsigned T_RCD = 5;
  localparam int unsigned T_RP  = 5;
  localparam int unsigned T_CL  = 5;

  localparam logic       RASN_IDLE = 1'b1;
  localparam logic       CASN_IDLE = 1'b1;
  localparam logic [3:0] WEN_IDLE  = 4'hf;
  localparam logic       RASN_ACT  = 1'b0;
  localparam logic       CASN_ACT  = 1'b1;
  localparam logic [3:0] WEN_ACT   = 4'hf;
  localparam logic       RASN_PRE  = 1'b0;
  localparam logic       CASN_PRE  = 1'b1;
  localparam logic [3:0] WEN_PRE   = 4'h0;
  localparam logic       RASN_COL  = 1'b1;
  localparam logic       CASN_COL  = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_PRE_WAIT,
    S_ACT,
    S_ACT_WAIT,
    S_COL,
    S_COL_WAIT,
    S_DONE
  } dram_state_e;

  typedef logic [2:0] wait_cnt_t;

  // PRE/ACT waits end one edge early because the next command is registered on the
  // exit edge; the column wait ends on the edge that samples dram_valid.
  function automatic wait_cnt_t wait_load(dram_state_e s);
    case (s)
      S_PRE:   return wait_cnt_t'(T_RP - 2);
      S_ACT:   return wait_cnt_t'(T_RCD - 2);
      default: return wait_cnt_t'(T_CL - 1);
    endcase
  endfunction

endpackage

// File: rtl/dram_controller_if.sv
// Request/response port plus DRAM pin bundle; slave is the controller's view.
interface dram_controller_if
  import dram_ctrl_pkg::*;
#(
  parameter int unsigned ROW_W  = ROW_W_DEF,
  parameter int unsigned COL_W  = COL_W_DEF,
  parameter int unsigned A_W    = A_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic                   req_valid;
  logic                   req_ready;
  logic [ROW_W+COL_W-1:0] req_addr;
  logic [3:0]             req_web;
  logic [DATA_W-1:0]      req_wdata;
  logic                   rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   dram_csn;
  logic                   dram_rasn;
  logic                   dram_casn;
  logic [3:0]             dram_wen;
  logic [A_W-1:0]         dram_a;
  logic [DATA_W-1:0]      dram_d;
  logic [DATA_W-1:0]      dram_q;
  logic                   dram_valid;

  modport slave (
    input  req_valid, req_addr, req_web, req_wdata, dram_q, dram_valid,
    output req_ready, rsp_valid, rsp_rdata,
           dram_csn, dram_rasn, dram_casn, dram_wen, dram_a, dram_d
  );

  modport master (
    output req_valid, req_addr, req_web, req_wdata, dram_q, dram_valid,
    input  req_ready, rsp_valid, rsp_rdata,
           dram_csn, dram_rasn, dram_casn, dram_wen, dram_a, dram_d
  );
endinterface

// File: rtl/dram_controller_wait_cnt.sv
// Loadable 3-bit down-counter that stops at zero; times every WAIT state.
module dram_wait_cnt
  import dram_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      load_i,
  input  wait_cnt_t load_val_i,
  output logic      zero_o
);
  wait_cnt_t cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 3'd1;
    end
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/dram_controller.sv
// Single-word DRAM initiator with open-page row management and registered DRAM pins.
module dram_controller
  import dram_ctrl_pkg::*;
#(
  parameter int unsigned ROW_W  = ROW_W_DEF,
  parameter int unsigned COL_W  = COL_W_DEF,
  parameter int unsigned A_W    = A_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input logic               ACLK,
  input logic               ARESETn,
  dram_controller_if.slave  bus
);
  dram_state_e            state_q;
  logic                   req_ready_q;
  logic                   rsp_valid_q;
  logic [DATA_W-1:0]      rsp_rdata_q;
  logic                   csn_q;
  logic                   rasn_q;
  logic                   casn_q;
  logic [3:0]             wen_q;
  logic [A_W-1:0]         a_q;
  logic [DATA_W-1:0]      d_q;
  logic [ROW_W+COL_W-1:0] addr_q;
  logic [3:0]             web_q;
  logic [DATA_W-1:0]      wdata_q;
  logic                   open_q;
  logic [ROW_W-1:0]       open_row_q;

  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;
  logic             cnt_load;
  logic             cnt_zero;

  assign req_row = bus.req_addr[ROW_W+COL_W-1:COL_W];
  assign req_col = bus.req_addr[COL_W-1:0];
  assign cur_row = addr_q[ROW_W+COL_W-1:COL_W];
  assign cur_col = addr_q[COL_W-1:0];

  assign cnt_load = (state_q == S_PRE) || (state_q == S_ACT) || (state_q == S_COL);

  dram_wait_cnt u_wait_cnt (
    .clk        (ACLK),
    .rst_n      (ARESETn),
    .load_i     (cnt_load),
    .load_val_i (wait_load(state_q)),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      csn_q       <= 1'b1;
      rasn_q      <= RASN_IDLE;
      casn_q      <= CASN_IDLE;
      wen_q       <= WEN_IDLE;
      a_q         <= '0;
      d_q         <= '0;
      addr_q      <= '0;
      web_q       <= WEN_IDLE;
      wdata_q     <= '0;
      open_q      <= 1'b0;
      open_row_q  <= '0;
    end else begin
      // Pins fall back to the idle encoding unless a command is issued this edge.
      csn_q       <= 1'b0;
      rasn_q      <= RASN_IDLE;
      casn_q      <= CASN_IDLE;
      wen_q       <= WEN_IDLE;
      a_q         <= '0;
      rsp_valid_q <= 1'b0;

      case (state_q)
        S_IDLE, S_DONE: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            addr_q      <= bus.req_addr;
            web_q       <= bus.req_web;
            wdata_q     <= bus.req_wdata;
            if (open_q && (open_row_q == req_row)) begin
              state_q <= S_COL;
              rasn_q  <= RASN_COL;
              casn_q  <= CASN_COL;
              wen_q   <= bus.req_web;
              a_q     <= A_W'(req_col);
              d_q     <= bus.req_wdata;
            end else if (open_q) begin
              state_q <= S_PRE;
              rasn_q  <= RASN_PRE;
              casn_q  <= CASN_PRE;
              wen_q   <= WEN_PRE;
              a_q     <= A_W'(open_row_q);
              open_q  <= 1'b0;
            end else begin
              state_q    <= S_ACT;
              rasn_q     <= RASN_ACT;
              casn_q     <= CASN_ACT;
              wen_q      <= WEN_ACT;
              a_q        <= A_W'(req_row);
              open_q     <= 1'b1;
              open_row_q <= req_row;
            end
          end
        end
        S_PRE: state_q <= S_PRE_WAIT;
        S_PRE_WAIT: begin
          if (cnt_zero) begin
            state_q    <= S_ACT;
            rasn_q     <= RASN_ACT;
            casn_q     <= CASN_ACT;
            wen_q      <= WEN_ACT;
            a_q        <= A_W'(cur_row);
            open_q     <= 1'b1;
            open_row_q <= cur_row;
          end
        end
        S_ACT: state_q <= S_ACT_WAIT;
        S_ACT_WAIT: begin
          if (cnt_zero) begin
            state_q <= S_COL;
            rasn_q  <= RASN_COL;
            casn_q  <= CASN_COL;
            wen_q   <= web_q;
            a_q     <= A_W'(cur_col);
            d_q     <= wdata_q;
          end
        end
        S_COL: state_q <= S_COL_WAIT;
        S_COL_WAIT: begin
          if (bus.dram_valid && (web_q == WEN_IDLE)) begin
            rsp_rdata_q <= bus.dram_q;
          end
          if (cnt_zero) begin
            state_q     <= S_DONE;
            rsp_valid_q <= 1'b1;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.dram_csn  = csn_q;
  assign bus.dram_rasn = rasn_q;
  assign bus.dram_casn = casn_q;
  assign bus.dram_wen  = wen_q;
  assign bus.dram_a    = a_q;
  assign bus.dram_d    = d_q;
endmodule

// File: tb/tb_dram_controller.sv
// Randomised bench: behavioural DRAM device with timing checks plus a request-level reference model.
module tb_dram_controller;
  import dram_ctrl_pkg::*;

  localparam int unsigned ROW_W  = 11;
  localparam int unsigned COL_W  = 10;
  localparam int unsigned A_W    = 11;
  localparam int unsigned DATA_W = 32;
  localparam int K_ACT = 0;
  localparam int K_PRE = 1;
  localparam int K_COL = 2;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  int unsigned cyc = 0;
  int unsigned since_rst = 0;
  int n_checks = 0;
  int n_pass = 0;

  dram_controller_if #(.ROW_W(ROW_W), .COL_W(COL_W), .A_W(A_W), .DATA_W(DATA_W)) dif ();

  dram_controller #(.ROW_W(ROW_W), .COL_W(COL_W), .A_W(A_W), .DATA_W(DATA_W)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (dif)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) begin
    cyc++;
    if (ARESETn) since_rst++;
    else since_rst = 0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DATA_W-1:0] init_word(input int unsigned k);
    return (k * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // ---------------- behavioural DRAM device ----------------
  typedef struct {
    int               kind;
    int unsigned      edge_n;
    logic [A_W-1:0]   a;
    logic [3:0]       wen;
    logic [DATA_W-1:0] d;
  } cmd_t;

  cmd_t              log_q[$];
  logic [DATA_W-1:0] dmem [int unsigned];
  bit                m_open;
  logic [ROW_W-1:0]  m_row;
  longint            m_last_act = -1000;
  longint            m_last_pre = -1000;
  longint            m_last_col = -1000;
  int                m_rd_cnt = 0;
  logic [DATA_W-1:0] m_rd_data;

  always @(negedge ACLK) begin
    longint e;
    bit is_idle, is_act, is_pre, is_col, known;
    int unsigned k;
    logic [DATA_W-1:0] w;
    cmd_t c;
    dif.dram_valid = 1'b0;
    dif.dram_q = $urandom;
    if (!ARESETn) begin
      m_open = 1'b0;
      m_rd_cnt = 0;
      m_last_act = -1000;
      m_last_pre = -1000;
      m_last_col = -1000;
    end else begin
      if (m_rd_cnt > 0) begin
        m_rd_cnt--;
        if (m_rd_cnt == 0) begin
          dif.dram_valid = 1'b1;
          dif.dram_q = m_rd_data;
        end
      end
      if (since_rst >= 1) begin
        e = longint'(cyc) + 1;
        known = !$isunknown({dif.dram_csn, dif.dram_rasn, dif.dram_casn, dif.dram_wen, dif.dram_a});
        is_idle = dif.dram_rasn && dif.dram_casn && dif.dram_wen == 4'hf && dif.dram_a == '0;
        is_act = !dif.dram_rasn && dif.dram_casn && dif.dram_wen == 4'hf;
        is_pre = !dif.dram_rasn && dif.dram_casn && dif.dram_wen == 4'h0;
        is_col = dif.dram_rasn && !dif.dram_casn;
        check("pins_legal", known && !dif.dram_csn && (is_idle || is_act || is_pre || is_col), 1);
        c.edge_n = cyc + 1;
        c.a = dif.dram_a;
        c.wen = dif.dram_wen;
        c.d = dif.dram_d;
        if (is_act) begin
          check("act_bank_closed", m_open, 0);
          check("tRP", (e - m_last_pre) >= T_RP, 1);
          m_open = 1'b1;
          m_row = dif.dram_a[ROW_W-1:0];
          m_last_act = e;
          c.kind = K_ACT;
          log_q.push_back(c);
        end
        if (is_pre) begin
          check("pre_bank_open", m_open, 1);
          check("pre_rd_inflight", m_rd_cnt != 0, 0);
          m_open = 1'b0;
          m_last_pre = e;
          c.kind = K_PRE;
          log_q.push_back(c);
        end
        if (is_col) begin
          check("col_bank_open", m_open, 1);
          check("tRCD", (e - m_last_act) >= T_RCD, 1);
          check("tCCD", (e - m_last_col) >= 5, 1);
          m_last_col = e;
          k = {m_row, dif.dram_a[COL_W-1:0]};
          w = dmem.exists(k) ? dmem[k] : init_word(k);
          if (dif.dram_wen == 4'hf) begin
            m_rd_cnt = T_CL;
            m_rd_data = w;
          end else begin
            for (int b = 0; b < 4; b++)
              if (!dif.dram_wen[b]) w[8*b +: 8] = dif.dram_d[8*b +: 8];
            dmem[k] = w;
          end
          c.kind = K_COL;
          log_q.push_back(c);
        end
      end
    end
  end

  // ---------------- request-level reference model ----------------
  bit                r_open = 1'b0;
  logic [ROW_W-1:0]  r_row = '0;
  logic [DATA_W-1:0] r_mem [int unsigned];
  logic [DATA_W-1:0] r_rdata = '0;

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, dif.req_ready, 0);
    check({tag, "_rsp_valid"}, dif.rsp_valid, 0);
    check({tag, "_rsp_rdata"}, dif.rsp_rdata, 0);
    check({tag, "_csn"}, dif.dram_csn, 1);
    check({tag, "_rasn"}, dif.dram_rasn, 1);
    check({tag, "_casn"}, dif.dram_casn, 1);
    check({tag, "_wen"}, dif.dram_wen, 4'hf);
    check({tag, "_a"}, dif.dram_a, 0);
    check({tag, "_d"}, dif.dram_d, 0);
  endtask

  task automatic wait_ready(output bit ok);
    int t = 0;
    while (!dif.req_ready && t < 50) begin
      @(negedge ACLK);
      t++;
    end
    ok = dif.req_ready;
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  task automatic do_req(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col,
                        input logic [3:0] web, input logic [DATA_W-1:0] wdata);
    int unsigned acc, base, idx, col_off, k;
    int kind, t;
    bit ok;
    logic [DATA_W-1:0] old, m;
    kind = !r_open ? 1 : ((r_row == row) ? 0 : 2);
    col_off = (kind == 0) ? 1 : ((kind == 1) ? 6 : 11);
    wait_ready(ok);
    if (!ok) return;
    base = log_q.size();
    dif.req_valid = 1'b1;
    dif.req_addr = {row, col};
    dif.req_web = web;
    dif.req_wdata = wdata;
    acc = cyc + 1;
    @(negedge ACLK);
    dif.req_valid = 1'b0;
    dif.req_addr = $urandom;
    dif.req_web = 4'($urandom);
    dif.req_wdata = $urandom;
    t = 0;
    while (!dif.rsp_valid && t < 40) begin
      @(negedge ACLK);
      t++;
    end
    if (!dif.rsp_valid) begin
      check("rsp_timeout", 0, 1);
      return;
    end
    check("rsp_edge", cyc - acc, col_off + 5);
    check("n_cmds", log_q.size() - base, kind + 1);
    if (log_q.size() - base == kind + 1) begin
      idx = base;
      if (kind == 2) begin
        check("pre_kind", log_q[idx].kind, K_PRE);
        check("pre_edge", log_q[idx].edge_n - acc, 1);
        check("pre_a", log_q[idx].a, A_W'(r_row));
        idx++;
      end
      if (kind >= 1) begin
        check("act_kind", log_q[idx].kind, K_ACT);
        check("act_edge", log_q[idx].edge_n - acc, col_off - 5);
        check("act_a", log_q[idx].a, A_W'(row));
        idx++;
      end
      check("col_kind", log_q[idx].kind, K_COL);
      check("col_edge", log_q[idx].edge_n - acc, col_off);
      check("col_a", log_q[idx].a, A_W'(col));
      check("col_wen", log_q[idx].wen, web);
      if (web != 4'hf) check("col_d", log_q[idx].d, wdata);
    end
    r_open = 1'b1;
    r_row = row;
    k = {row, col};
    old = r_mem.exists(k) ? r_mem[k] : init_word(k);
    if (web == 4'hf) begin
      r_rdata = old;
      check("rdata", dif.rsp_rdata, old);
    end else begin
      m = {{8{~web[3]}}, {8{~web[2]}}, {8{~web[1]}}, {8{~web[0]}}};
      r_mem[k] = (old & ~m) | (wdata & m);
      check("rdata_hold", dif.rsp_rdata, r_rdata);
    end
    @(negedge ACLK);
    check("rsp_pulse", dif.rsp_valid, 0);
  endtask

  task automatic abort_after_act(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
    int unsigned base;
    int t;
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    base = log_q.size();
    dif.req_valid = 1'b1;
    dif.req_addr = {row, col};
    dif.req_web = 4'hf;
    dif.req_wdata = '0;
    @(negedge ACLK);
    dif.req_valid = 1'b0;
    t = 0;
    while (!(log_q.size() > base && log_q[log_q.size()-1].kind == K_ACT) && t < 20) begin
      @(negedge ACLK);
      t++;
    end
    check("abort_act_seen", log_q.size() > base && log_q[log_q.size()-1].kind == K_ACT, 1);
    @(negedge ACLK);
    #2 ARESETn = 1'b0;
    #1 check_reset_vals("mid_rst");
    repeat (2) @(negedge ACLK);
    #2 ARESETn = 1'b1;
    r_open = 1'b0;
    r_rdata = '0;
  endtask

  initial begin
    #1000000;
    check("watchdog", 0, 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    dif.req_valid = 1'b0;
    dif.req_addr = '0;
    dif.req_web = 4'hf;
    dif.req_wdata = '0;
    repeat (2) @(negedge ACLK);
    #1 check_reset_vals("por");
    @(negedge ACLK);
    #2 ARESETn = 1'b1;

    do_req(11'd3, 10'd5, 4'h0, 32'hDEADBEEF);
    do_req(11'd3, 10'd5, 4'hf, '0);
    check("readback", dif.rsp_rdata, 32'hDEADBEEF);
    do_req(11'd3, 10'd5, 4'b1110, 32'h000000AA);
    do_req(11'd3, 10'd5, 4'hf, '0);
    check("byte_merge", dif.rsp_rdata, 32'hDEADBEAA);

    do_req(11'd7, 10'd2, 4'hf, '0);
    do_req(11'd3, 10'd9, 4'hf, '0);
    for (int i = 0; i < 4; i++) do_req(11'd3, COL_W'(i), 4'hf, '0);

    abort_after_act(11'd6, 10'd4);
    do_req(11'd6, 10'd4, 4'hf, '0);

    for (int n = 0; n < 60; n++) begin
      logic [3:0] web;
      case ($urandom_range(0, 2))
        0: web = 4'hf;
        1: web = 4'h0;
        default: web = 4'($urandom_range(0, 14));
      endcase
      do_req(ROW_W'($urandom_range(0, 3)), COL_W'($urandom_range(0, 7)), web, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
